memu_dbus_ctrl: RTL and testbench
=================================

# memu_dbus_ctrl

Memory-stage responder for the multi-cycle control FSM. It accepts the `memu_valid`/`DMre`/`DMwe` request issued in the memory state and runs a request/response transaction on the 64-bit data bus. It aligns and sign- or zero-extends load data, or builds byte strobes for stores. When done, it returns a one-cycle `memu_finish` together with `memu_rdata` and `memu_err`.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles spent waiting in `REQ` or in `WAIT_R` before the access is aborted.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk` (in, 1): clock; all state changes on the rising edge.
  - `rst` (in, 1): reset; sampled on the rising edge of `clk`; active when 0.
- Control-side ports:
  - `memu_valid` (in, 1): held high by the control FSM while it is in the memory state.
  - `DMre` (in, 1): load request; sampled in `IDLE`.
  - `DMwe` (in, 1): store request; sampled in `IDLE`.
  - `funct3` (in, 3): access size and signedness, RISC-V encoding.
    - Loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
    - Stores: 000 sb, 001 sh, 010 sw, 011 sd.
  - `addr` (in, 64): effective address (ALU result).
  - `wdata` (in, 64): store data (rs2), right-aligned.
  - `memu_finish` (out, 1): one-cycle completion pulse.
  - `memu_rdata` (out, 64): extended load data; valid while `memu_finish`=1 and held until the next access starts.
  - `memu_err` (out, 1): valid with `memu_finish`; 1 means misaligned access or timeout.
- Data-bus ports:
  - `dbus_req` (out, 1): request valid.
  - `dbus_we` (out, 1): 1 = write, 0 = read.
  - `dbus_addr` (out, 64): request address, `{addr[63:3],3'b000}`.
  - `dbus_wdata` (out, 64): `wdata` shifted left by `addr[2:0]*8`.
  - `dbus_wstrb` (out, 8): byte-enable mask for the write.
  - `dbus_ready` (in, 1): request accepted in this cycle.
  - `dbus_rvalid` (in, 1): read data valid.
  - `dbus_rdata` (in, 64): read data.

## Operation
States: `IDLE`, `REQ`, `WAIT_R`, `DONE`.
- **IDLE**
  - Entry condition: `memu_valid`=1.
  - If both `DMre`=0 and `DMwe`=0: go to `DONE` with `err`=0 and no bus access.
  - If `DMre` and `DMwe` are both 1: `DMwe` wins.
  - Misaligned access: go to `DONE` with `err`=1 and no bus access. Misaligned means:
    - half-word: `addr[0]`≠0;
    - word: `addr[1:0]`≠0;
    - double-word: `addr[2:0]`≠0.
  - Otherwise: latch `addr`, `funct3`, the shifted write data, the strobe and `we` into registers, then go to `REQ`.
- **REQ**
  - `dbus_req`=1, and all `dbus_*` outputs are stable.
  - On `dbus_ready`=1: go to `DONE` for a write, or to `WAIT_R` for a read.
- **WAIT_R**
  - On `dbus_rvalid`=1: capture the extended data into `memu_rdata` and go to `DONE`.
  - `dbus_rvalid` is ignored in every other state.
- **DONE**
  - `memu_finish`=1 for exactly one cycle, then go to `IDLE`.
- **Timeout**
  - A wait counter clears on entry to `REQ` and on entry to `WAIT_R`, and increments each cycle spent in those states.
  - When the count reaches `TIMEOUT`: go to `DONE` with `err`=1 and `memu_rdata`=0, and drop `dbus_req`.
  - A `dbus_ready` or `dbus_rvalid` arriving in that same cycle is ignored.

Strobes and load extension:
- `dbus_wstrb`:
  - sb: `8'h01<<off`;
  - sh: `8'h03<<off`;
  - sw: `8'h0F<<off`;
  - sd: `8'hFF`.
  - `off`=`addr[2:0]`. The strobe is 0 for reads.
- Load data `sh` = `dbus_rdata >> (off*8)`:
  - lb/lh/lw take the low 8/16/32 bits of `sh` and sign-extend them to 64 bits;
  - lbu/lhu/lwu zero-extend the same fields;
  - ld takes all 64 bits of `sh`.

## Timing
- **Reset** (`rst`=0 at a clock edge): next cycle the state is `IDLE` and every output is 0 (`memu_finish`, `memu_err`, `memu_rdata`, all `dbus_*`). An in-flight bus transaction is abandoned; any late `rvalid` is ignored in `IDLE`.
- **Outputs are registered**; no combinational path exists from `dbus_*` inputs to outputs.
- **Latency**, with `memu_valid` first high in cycle 0:
  - store: `dbus_req` in cycle 1; if `ready` arrives in cycle 1, `memu_finish` is high in cycle 2.
  - load: `ready` in cycle 1 and `rvalid` in cycle 2 give `memu_finish` in cycle 3.
  - misaligned access or no-op: `memu_finish` in cycle 1.
- **Finish handshake**: the control FSM leaves the memory state on the edge at which it samples `memu_finish`=1. Therefore `memu_valid` is low when `IDLE` is re-entered. If `memu_valid` is still high in `IDLE`, it starts a new access.
- **Bus ordering**: the bus asserts `rvalid` no earlier than the cycle after `ready`.

## Test plan
1. Store with immediate ready: sd, `addr`=0x1000, `wdata`=0x1122334455667788, `ready` in cycle 1.
   - Bus in cycle 1: `dbus_addr`=0x1000, `wstrb`=0xFF, `we`=1.
   - Cycle 2: `memu_finish`=1 with `memu_err`=0.
2. Load with extension: `addr`=0x2003, `dbus_rdata`=0x00000000_80FF0000, `ready` in cycle 1, `rvalid` in cycle 3.
   - lb gives `memu_rdata`=0xFFFFFFFFFFFFFF80; lbu gives 0x80.
   - `memu_finish` is high in cycle 4.
3. Byte store: sb at `addr`=0x3005 with `wdata`=0xAB.
   - `wstrb`=0x20, `dbus_wdata[47:40]`=0xAB, `dbus_addr`=0x3000.
4. Misaligned: sw at `addr`=0x4002.
   - `dbus_req` is never asserted; cycle 1: `memu_finish`=1, `memu_err`=1.
5. Timeout: `TIMEOUT`=4, ld with `ready` never asserted.
   - `dbus_req` is high in cycles 1–4; `memu_finish`=1, `memu_err`=1, `memu_rdata`=0 in cycle 5.
6. Reset mid-access: `rst`=0 while in `WAIT_R`.
   - All outputs 0 the next cycle; a subsequent `rvalid` pulse produces no `memu_finish`.

Source files
------------

// File: rtl/memu_dbus_ctrl_if.sv
// Request/response data-bus bundle between the memory-stage controller and the memory.
interface memu_dbus_ctrl_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [63:0] dbus_addr;
  logic [63:0] dbus_wdata;
  logic [7:0]  dbus_wstrb;
  logic        dbus_ready;
  logic        dbus_rvalid;
  logic [63:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
    input  dbus_ready, dbus_rvalid, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
    output dbus_ready, dbus_rvalid, dbus_rdata
  );
endinterface

// File: rtl/memu_dbus_ctrl.sv
// Memory-stage responder: runs one load/store on the data bus per memu_valid request,
// aligns/extends load data, builds store strobes, and pulses memu_finish when done.
module memu_dbus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memu_valid,
  input  logic        DMre,
  input  logic        DMwe,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        memu_finish,
  output logic [63:0] memu_rdata,
  output logic        memu_err,
  memu_dbus_ctrl_if.master dbus
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]  f3_q, f3_n;
  logic [2:0]  off_q, off_n;
  logic        finish_n, err_n;
  logic [63:0] rdata_n;
  logic        req_q, req_n;
  logic        we_q, we_n;
  logic [63:0] baddr_q, baddr_n;
  logic [63:0] bwdata_q, bwdata_n;
  logic [7:0]  bstrb_q, bstrb_n;
  logic        misaligned;
  logic [7:0]  strb;

  function automatic logic [63:0] load_ext(input logic [2:0] f3, input logic [63:0] sh);
    case (f3)
      3'b000:  return {{56{sh[7]}}, sh[7:0]};
      3'b001:  return {{48{sh[15]}}, sh[15:0]};
      3'b010:  return {{32{sh[31]}}, sh[31:0]};
      3'b100:  return {56'd0, sh[7:0]};
      3'b101:  return {48'd0, sh[15:0]};
      3'b110:  return {32'd0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    misaligned = 1'b0;
    strb       = 8'hFF;
    case (funct3[1:0])
      2'b00: strb = 8'h01 << addr[2:0];
      2'b01: begin misaligned = addr[0];         strb = 8'h03 << addr[2:0]; end
      2'b10: begin misaligned = |addr[1:0];      strb = 8'h0F << addr[2:0]; end
      default: misaligned = |addr[2:0];
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    f3_n     = f3_q;
    off_n    = off_q;
    finish_n = 1'b0;
    err_n    = 1'b0;
    rdata_n  = memu_rdata;
    req_n    = req_q;
    we_n     = we_q;
    baddr_n  = baddr_q;
    bwdata_n = bwdata_q;
    bstrb_n  = bstrb_q;
    case (state)
      IDLE: begin
        if (memu_valid) begin
          rdata_n = '0;
          if (!DMre && !DMwe) begin
            state_n  = DONE;
            finish_n = 1'b1;
          end else if (misaligned) begin
            state_n  = DONE;
            finish_n = 1'b1;
            err_n    = 1'b1;
          end else begin
            state_n  = REQ;
            cnt_n    = '0;
            req_n    = 1'b1;
            we_n     = DMwe;
            f3_n     = funct3;
            off_n    = addr[2:0];
            baddr_n  = {addr[63:3], 3'b000};
            bwdata_n = wdata << {addr[2:0], 3'b000};
            bstrb_n  = DMwe ? strb : 8'h00;
          end
        end
      end
      REQ: begin
        cnt_n = cnt + 1'b1;
        // Timeout takes priority over a ready arriving in the same cycle.
        if (cnt == TLAST) begin
          state_n  = DONE;
          req_n    = 1'b0;
          finish_n = 1'b1;
          err_n    = 1'b1;
          rdata_n  = '0;
        end else if (dbus.dbus_ready) begin
          req_n = 1'b0;
          if (we_q) begin
            state_n  = DONE;
            finish_n = 1'b1;
          end else begin
            state_n = WAIT_R;
            cnt_n   = '0;
          end
        end
      end
      WAIT_R: begin
        cnt_n = cnt + 1'b1;
        if (cnt == TLAST) begin
          state_n  = DONE;
          finish_n = 1'b1;
          err_n    = 1'b1;
          rdata_n  = '0;
        end else if (dbus.dbus_rvalid) begin
          state_n  = DONE;
          finish_n = 1'b1;
          rdata_n  = load_ext(f3_q, dbus.dbus_rdata >> {off_q, 3'b000});
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      memu_finish <= 1'b0;
      memu_err    <= 1'b0;
      memu_rdata  <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      baddr_q     <= '0;
      bwdata_q    <= '0;
      bstrb_q     <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      f3_q        <= f3_n;
      off_q       <= off_n;
      memu_finish <= finish_n;
      memu_err    <= err_n;
      memu_rdata  <= rdata_n;
      req_q       <= req_n;
      we_q        <= we_n;
      baddr_q     <= baddr_n;
      bwdata_q    <= bwdata_n;
      bstrb_q     <= bstrb_n;
    end
  end

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = baddr_q;
  assign dbus.dbus_wdata = bwdata_q;
  assign dbus.dbus_wstrb = bstrb_q;

endmodule

// File: tb/tb_memu_dbus_ctrl.sv
// Directed bench for memu_dbus_ctrl with a finish-time scoreboard (TIMEOUT=4).
module tb_memu_dbus_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        memu_valid, DMre, DMwe;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata;
  logic        memu_finish, memu_err;
  logic [63:0] memu_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rd_chk;
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  memu_dbus_ctrl_if bus();

  memu_dbus_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .memu_valid(memu_valid), .DMre(DMre), .DMwe(DMwe),
    .funct3(funct3), .addr(addr), .wdata(wdata), .memu_finish(memu_finish),
    .memu_rdata(memu_rdata), .memu_err(memu_err), .dbus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every finish pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (memu_finish) begin
      if (sbq.size() == 0) begin
        chk("unexpected_finish", 64'(memu_finish), 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_err", 64'(memu_err), 64'(e.err));
        if (e.rd_chk) chk("sb_rdata", memu_rdata, e.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic re, input logic we, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd);
    memu_valid = 1'b1; DMre = re; DMwe = we; funct3 = f3; addr = a; wdata = wd;
  endtask

  task automatic release_ctrl();
    step();
    memu_valid = 1'b0; DMre = 1'b0; DMwe = 1'b0;
    chk("finish_one_cycle", 64'(memu_finish), 64'd0);
  endtask

  task automatic do_store(input logic re, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input logic [7:0] exp_strb,
                          input logic [63:0] exp_wd, input int rdy_delay);
    start(re, 1'b1, f3, a, wd);
    sbq.push_back('{1'b0, 64'd0, 1'b0});
    step();
    chk("st_req", 64'(bus.dbus_req), 64'd1);
    chk("st_we", 64'(bus.dbus_we), 64'd1);
    chk("st_addr", bus.dbus_addr, a & ~64'h7);
    chk("st_strb", 64'(bus.dbus_wstrb), 64'(exp_strb));
    chk("st_wdata", bus.dbus_wdata, exp_wd);
    for (int i = 0; i < rdy_delay; i++) begin
      chk("st_early_finish", 64'(memu_finish), 64'd0);
      step();
      chk("st_req_hold", 64'(bus.dbus_req), 64'd1);
    end
    bus.dbus_ready = 1'b1;
    step();
    bus.dbus_ready = 1'b0;
    chk("st_finish", 64'(memu_finish), 64'd1);
    chk("st_req_drop", 64'(bus.dbus_req), 64'd0);
    release_ctrl();
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rd,
                         input logic [63:0] exp, input int rv_gap);
    start(1'b1, 1'b0, f3, a, 64'd0);
    sbq.push_back('{1'b1, exp, 1'b0});
    step();
    chk("ld_req", 64'(bus.dbus_req), 64'd1);
    chk("ld_we", 64'(bus.dbus_we), 64'd0);
    chk("ld_strb", 64'(bus.dbus_wstrb), 64'd0);
    chk("ld_addr", bus.dbus_addr, a & ~64'h7);
    bus.dbus_ready = 1'b1;
    step();
    bus.dbus_ready = 1'b0;
    chk("ld_req_drop", 64'(bus.dbus_req), 64'd0);
    for (int i = 1; i < rv_gap; i++) begin
      chk("ld_early_finish", 64'(memu_finish), 64'd0);
      step();
    end
    chk("ld_early_finish", 64'(memu_finish), 64'd0);
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = rd;
    step();
    bus.dbus_rvalid = 1'b0;
    chk("ld_finish", 64'(memu_finish), 64'd1);
    chk("ld_rdata", memu_rdata, exp);
    release_ctrl();
  endtask

  task automatic do_short(input logic re, input logic we, input logic [2:0] f3,
                          input logic [63:0] a, input logic exp_err);
    start(re, we, f3, a, 64'hFFFF_FFFF_FFFF_FFFF);
    sbq.push_back('{1'b0, 64'd0, exp_err});
    step();
    chk("short_finish", 64'(memu_finish), 64'd1);
    chk("short_err", 64'(memu_err), 64'(exp_err));
    chk("short_no_req", 64'(bus.dbus_req), 64'd0);
    release_ctrl();
  endtask

  initial begin
    rst = 1'b0; memu_valid = 1'b0; DMre = 1'b0; DMwe = 1'b0; funct3 = '0;
    addr = '0; wdata = '0;
    bus.dbus_ready = 1'b0; bus.dbus_rvalid = 1'b0; bus.dbus_rdata = '0;
    step(); step();
    chk("rst_finish", 64'(memu_finish), 64'd0);
    chk("rst_req", 64'(bus.dbus_req), 64'd0);
    chk("rst_rdata", memu_rdata, 64'd0);
    rst = 1'b1;
    step();

    // Stores
    do_store(1'b0, 3'b011, 64'h1000, 64'h1122334455667788, 8'hFF, 64'h1122334455667788, 0);
    do_store(1'b0, 3'b000, 64'h3005, 64'h0000_0000_0000_00AB, 8'h20, 64'h0000_AB00_0000_0000, 0);
    do_store(1'b0, 3'b001, 64'h3006, 64'h0000_0000_0000_BEEF, 8'hC0, 64'hBEEF_0000_0000_0000, 2);
    do_store(1'b1, 3'b010, 64'h3004, 64'h0000_0000_DEAD_BEEF, 8'hF0, 64'hDEAD_BEEF_0000_0000, 1);

    // Loads with alignment and extension
    do_load(3'b000, 64'h2003, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80, 2);
    do_load(3'b100, 64'h2003, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080, 2);
    do_load(3'b001, 64'h2002, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_80FF, 1);
    do_load(3'b101, 64'h2002, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_80FF, 1);
    do_load(3'b010, 64'h2000, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_80FF_0000, 1);
    do_load(3'b110, 64'h2000, 64'h0000_0000_80FF_0000, 64'h0000_0000_80FF_0000, 1);
    do_load(3'b011, 64'h2008, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211, 1);
    do_load(3'b000, 64'h2007, 64'h7F00_0000_0000_0000, 64'h0000_0000_0000_007F, 1);

    // Misaligned and no-op
    do_short(1'b0, 1'b1, 3'b010, 64'h4002, 1'b1);
    do_short(1'b1, 1'b0, 3'b001, 64'h4001, 1'b1);
    do_short(1'b1, 1'b0, 3'b011, 64'h4004, 1'b1);
    do_short(1'b1, 1'b1, 3'b011, 64'h4004, 1'b1);
    do_short(1'b0, 1'b0, 3'b000, 64'h4001, 1'b0);

    // Timeout in REQ; a ready in the timeout cycle is ignored
    start(1'b1, 1'b0, 3'b011, 64'h5000, 64'd0);
    sbq.push_back('{1'b1, 64'd0, 1'b1});
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("to_req_high", 64'(bus.dbus_req), 64'd1);
      chk("to_no_finish", 64'(memu_finish), 64'd0);
      if (c == 4) bus.dbus_ready = 1'b1;
    end
    step();
    bus.dbus_ready = 1'b0;
    chk("to_finish", 64'(memu_finish), 64'd1);
    chk("to_err", 64'(memu_err), 64'd1);
    chk("to_rdata", memu_rdata, 64'd0);
    chk("to_req_drop", 64'(bus.dbus_req), 64'd0);
    release_ctrl();

    // Timeout in WAIT_R; rvalid in the timeout cycle is ignored
    start(1'b1, 1'b0, 3'b010, 64'h5008, 64'd0);
    sbq.push_back('{1'b1, 64'd0, 1'b1});
    step();
    bus.dbus_ready = 1'b1;
    step();
    bus.dbus_ready = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      chk("tor_no_finish", 64'(memu_finish), 64'd0);
      if (c == 5) begin
        bus.dbus_rvalid = 1'b1;
        bus.dbus_rdata  = 64'h1234_5678_1234_5678;
      end
      step();
    end
    bus.dbus_rvalid = 1'b0;
    chk("tor_finish", 64'(memu_finish), 64'd1);
    chk("tor_err", 64'(memu_err), 64'd1);
    chk("tor_rdata", memu_rdata, 64'd0);
    release_ctrl();

    // Reset while in WAIT_R; a late rvalid must not complete anything
    start(1'b1, 1'b0, 3'b011, 64'h6008, 64'd0);
    step();
    bus.dbus_ready = 1'b1;
    step();
    bus.dbus_ready = 1'b0;
    rst = 1'b0; memu_valid = 1'b0; DMre = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst_finish", 64'(memu_finish), 64'd0);
    chk("mrst_err", 64'(memu_err), 64'd0);
    chk("mrst_rdata", memu_rdata, 64'd0);
    chk("mrst_req", 64'(bus.dbus_req), 64'd0);
    chk("mrst_we", 64'(bus.dbus_we), 64'd0);
    chk("mrst_addr", bus.dbus_addr, 64'd0);
    chk("mrst_wdata", bus.dbus_wdata, 64'd0);
    chk("mrst_strb", 64'(bus.dbus_wstrb), 64'd0);
    bus.dbus_rvalid = 1'b1;
    bus.dbus_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    step();
    bus.dbus_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("mrst_no_finish", 64'(memu_finish), 64'd0);
      step();
    end

    // Normal operation after reset
    do_load(3'b011, 64'h7000, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 1);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
